down_counter_timer: RTL and testbench

Programmable 12-bit countdown timer. It counts down from a software-loaded value to zero and signals terminal count, in one-shot or auto-reload mode. It sits beside up_counter in the lab timing subsystem and generates timeouts and periodic ticks from the same enable strobe that up_counter uses.

---
 rtl/down_counter_timer.sv | 98 +++++++++
 tb/tb_down_counter_timer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/down_counter_timer.sv
// Programmable countdown timer with one-shot and auto-reload modes.
// Decrements on enable strobes while running and emits a one-cycle terminal-count pulse.
module down_counter_timer #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StRun, StHold, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic             count_en;

  // Counting is blocked by load/stop but not by start, which is a no-op while running.
  assign count_en = !load && !stop && (state_q == StRun) && enable;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    done_d   = done_q;

    if (load) begin
      reload_d = load_value;
      count_d  = load_value;
      state_d  = StIdle;
      done_d   = 1'b0;
    end else if (stop) begin
      if (state_q == StRun) begin
        state_d = StHold;
      end
    end else if (start) begin
      unique case (state_q)
        StIdle, StDone: begin
          if (reload_q != '0) begin
            count_d = reload_q;
            state_d = StRun;
            done_d  = 1'b0;
          end
        end
        StHold:  state_d = StRun;
        default: ;
      endcase
    end

    if (count_en) begin
      if (count_q != '0) begin
        count_d = count_q - 1'b1;
      end else begin
        tc_d = 1'b1;
        if (mode) begin
          count_d = reload_q;
        end else begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      done_q   <= done_d;
    end
  end

  assign count = count_q;
  assign busy  = (state_q == StRun) || (state_q == StHold);
  assign tc    = tc_q;
  assign done  = done_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: directed scenarios plus random stimulus,
// every cycle compared against a behavioural timer model.
module tb_down_counter_timer;

  localparam int unsigned W = 12;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         load, start, stop, mode, enable;
  logic [W-1:0] load_value;
  logic [W-1:0] count;
  logic         busy, tc, done;

  int checks = 0;
  int failures = 0;

  // Behavioural model: timer is either inactive, running, or paused; done is a sticky flag.
  int m_count, m_reload;
  bit m_active, m_paused, m_done, m_tc;

  down_counter_timer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .load_value(load_value),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .enable    (enable),
    .count     (count),
    .busy      (busy),
    .tc        (tc),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_reload = 0;
    m_active = 0; m_paused = 0; m_done = 0; m_tc = 0;
  endtask

  task automatic model_edge();
    bit running;
    running = m_active && !m_paused;
    m_tc = 0;
    if (!reset_n) begin
      model_reset();
    end else if (load) begin
      m_reload = int'(load_value);
      m_count  = int'(load_value);
      m_active = 0; m_paused = 0; m_done = 0;
    end else if (stop) begin
      if (running) m_paused = 1;
    end else if (start && !running) begin
      if (m_paused) m_paused = 0;
      else if (m_reload != 0) begin
        m_count = m_reload; m_active = 1; m_done = 0;
      end
    end else if (running && enable) begin
      if (m_count > 0) m_count = m_count - 1;
      else begin
        m_tc = 1;
        if (mode) m_count = m_reload;
        else begin m_active = 0; m_done = 1; end
      end
    end
  endtask

  task automatic compare_all();
    chk("count", int'(count), m_count);
    chk("busy", int'(busy), int'(m_active));
    chk("tc", int'(tc), int'(m_tc));
    chk("done", int'(done), int'(m_done));
  endtask

  // Drive one clock edge worth of inputs from a negedge, update the model, compare at next negedge.
  task automatic cyc(input bit l, input int lv, input bit st, input bit sp, input bit md,
                     input bit en);
    load = l; load_value = W'(lv); start = st; stop = sp; mode = md; enable = en;
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  int tcs;

  initial begin
    reset_n = 1'b0;
    load = 0; load_value = '0; start = 0; stop = 0; mode = 0; enable = 0;
    model_reset();
    @(negedge clk);
    compare_all();
    reset_n = 1'b1;

    // 1: reset mid-run at count 7, then start without load is ignored
    cyc(1, 10, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 0, 0, 1);
    chk("pre_reset_count", int'(count), 7);
    #2 reset_n = 1'b0;
    model_reset();
    #1 compare_all();
    @(negedge clk);
    repeat (2) cyc(0, 0, 0, 0, 0, 1);
    reset_n = 1'b1;
    cyc(0, 0, 1, 0, 0, 1);
    chk("reset_start_ignored_busy", int'(busy), 0);

    // 2: one-shot from 5
    cyc(1, 5, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 1);
    chk("oneshot_first", int'(count), 5);
    repeat (5) cyc(0, 0, 0, 0, 0, 1);
    chk("oneshot_zero_no_tc", int'(tc), 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("oneshot_tc", int'(tc), 1);
    chk("oneshot_done", int'(done), 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("oneshot_tc_once", int'(tc), 0);

    // 3: auto-reload from 3, tc every 4 strobes
    cyc(1, 3, 0, 0, 1, 1);
    cyc(0, 0, 1, 0, 1, 1);
    tcs = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 0, 0, 1, 1);
      tcs += int'(tc);
    end
    chk("reload_tc_count", tcs, 3);
    chk("reload_busy", int'(busy), 1);

    // 4: enable gating, stop/hold, resume
    cyc(1, 6, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("gated_count", int'(count), 4);
    cyc(0, 0, 0, 1, 0, 1);
    repeat (10) cyc(0, 0, 0, 0, 0, 1);
    chk("hold_count", int'(count), 4);
    chk("hold_busy", int'(busy), 1);
    cyc(0, 0, 1, 1, 0, 1);
    chk("stop_start_hold", int'(count), 4);
    cyc(0, 0, 1, 0, 0, 1);
    repeat (4) cyc(0, 0, 0, 0, 0, 1);
    chk("resume_zero", int'(count), 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("resume_tc", int'(tc), 1);

    // 5: load overrides start/stop mid-run
    cyc(1, 12, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 0, 0, 1);
    chk("mid_run_9", int'(count), 9);
    cyc(1, 2, 1, 1, 0, 1);
    chk("override_count", int'(count), 2);
    chk("override_busy", int'(busy), 0);
    cyc(0, 0, 1, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 0, 0, 1);
    chk("override_tc", int'(tc), 1);

    // 6: zero load ignored; full-scale load runs 4096 strobes
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 1);
    chk("zero_start_busy", int'(busy), 0);
    cyc(1, 4095, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 1);
    repeat (4095) cyc(0, 0, 0, 0, 0, 1);
    chk("full_zero", int'(count), 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("full_tc", int'(tc), 1);
    chk("full_no_wrap", int'(count), 0);

    // Random phase
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 15) == 0),
          ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 9)),
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0),
          1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 999) == 0) begin
        #3 reset_n = 1'b0;
        model_reset();
        #1 compare_all();
        @(negedge clk);
        reset_n = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
